// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared CPU front-end definitions: datapath width, reset vector, PC step and
// the fetch state encoding used by the PC owner and branch control.
package fetch_redirect_ctrl_pkg;

    localparam int unsigned CPU_XLEN = 32;
    localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
    localparam int unsigned PC_INC = 4;

    // Kept as plain constants so older netlists and dumps decode identically.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Instruction-memory request/acknowledge bus; the fetch unit is the master.
interface fetch_redirect_ctrl_if
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = CPU_XLEN
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_redirect_ctrl_fetch_buffer.sv
// One-entry instruction/PC holding register: loads on demand, holds while the
// consumer stalls, drains when consumed and clears on flush.
module fetch_buffer
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = CPU_XLEN
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            stall,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic            free,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    // Space is available next cycle if empty now or the current entry leaves.
    assign free = !valid || !stall;

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            // NOTE: the payload is reset too because it is a visible output defined as zero in reset.
            inst  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (!stall) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch front end: owns the PC, fetches over a req/ack bus into a one-entry
// buffer, and redirects on taken branches while squashing stale responses.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN       = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(CPU_RESET_ADDR)
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_redirect,
    input  logic [XLEN-1:0]       i_target,
    input  logic                  i_stall,
    fetch_redirect_ctrl_if.master imem,
    output logic                  o_inst_valid,
    output logic [XLEN-1:0]       o_inst,
    output logic [XLEN-1:0]       o_pc,
    output logic                  o_flush,
    output logic                  o_misaligned
);

    logic [1:0]      state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] hold_addr;
    logic            discard, discard_d;
    logic            started;
    logic            req, xfer, redirect_ok, target_bad, buf_free, load;

    // The request is held off until the first edge after reset release.
    assign req         = started && (state == ST_REQ);
    assign imem.req    = req;
    assign imem.addr   = discard ? hold_addr : pc;
    assign xfer        = req && imem.ack;
    assign redirect_ok = i_redirect && (state != ST_HALT);
    assign target_bad  = is_misaligned(i_target[1:0]);
    assign load        = xfer && !discard && !i_redirect && buf_free;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d   = state;
        pc_d      = pc;
        discard_d = discard;
        if (redirect_ok) begin
            pc_d      = i_target;
            state_d   = target_bad ? ST_HALT : ST_REQ;
            // A request still waiting for its ack must finish on the old address.
            discard_d = !target_bad && req && !imem.ack;
        end else if (state == ST_REQ) begin
            if (xfer) begin
                discard_d = 1'b0;
                if (load) begin
                    pc_d = pc + XLEN'(PC_INC);
                end else if (!discard) begin
                    // Buffer full and stalled: drop the word and refetch the same PC later.
                    state_d = ST_IDLE;
                end
            end
        end else if (state == ST_IDLE && buf_free) begin
            state_d = ST_REQ;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_REQ;
            pc           <= RESET_ADDR;
            hold_addr    <= RESET_ADDR;
            discard      <= 1'b0;
            started      <= 1'b0;
            o_flush      <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            discard <= discard_d;
            started <= 1'b1;
            o_flush <= redirect_ok;
            if (!discard) begin
                hold_addr <= pc;
            end
            if (redirect_ok && target_bad) begin
                o_misaligned <= 1'b1;
            end
        end
    end

    fetch_buffer #(
        .XLEN (XLEN)
    ) u_fetch_buffer (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (redirect_ok),
        .load      (load),
        .stall     (i_stall),
        .load_inst (imem.rdata),
        .load_pc   (pc),
        .valid     (o_inst_valid),
        .free      (buf_free),
        .inst      (o_inst),
        .pc        (o_pc)
    );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, multi-cycle corner
// sequences, and a randomized run against an instruction-stream reference.
module tb_fetch_redirect_ctrl;
    import fetch_redirect_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_redirect = 1'b0;
    logic [XLEN-1:0] i_target = '0;
    logic            i_stall = 1'b0;
    logic            o_inst_valid;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_pc;
    logic            o_flush;
    logic            o_misaligned;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    fetch_redirect_ctrl_if #(.XLEN(XLEN)) imem ();

    fetch_redirect_ctrl #(
        .XLEN       (XLEN),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_redirect   (i_redirect),
        .i_target     (i_target),
        .i_stall      (i_stall),
        .imem         (imem),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_flush      (o_flush),
        .o_misaligned (o_misaligned)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    assign imem.rdata = mem_word(imem.addr);

    initial imem.ack = 1'b0;

    function automatic logic [31:0] b32(input logic b);
        return {31'b0, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic redir, input logic [31:0] tgt, input logic ack);
        i_stall    = stall;
        i_redirect = redir;
        i_target   = tgt;
        imem.ack   = ack;
    endtask

    // One cycle: check the registered outputs, then apply this cycle's inputs.
    task automatic seq(input string tag,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc,
                       input logic e_flush, input logic e_mis,
                       input logic stall, input logic redir,
                       input logic [31:0] tgt, input logic ack);
        @(negedge i_clk);
        check({tag, " req"}, b32(imem.req), b32(e_req));
        if (e_req) check({tag, " addr"}, imem.addr, e_addr);
        check({tag, " valid"}, b32(o_inst_valid), b32(e_valid));
        if (e_valid) begin
            check({tag, " pc"}, o_pc, e_pc);
            check({tag, " inst"}, o_inst, mem_word(e_pc));
        end
        check({tag, " flush"}, b32(o_flush), b32(e_flush));
        check({tag, " misaligned"}, b32(o_misaligned), b32(e_mis));
        drive(stall, redir, tgt, ack);
    endtask

    // Pulse reset for one cycle, check reset values, release at a falling edge.
    task automatic do_reset(input logic ack_lvl);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, ack_lvl);
        @(negedge i_clk);
        check("reset req", b32(imem.req), 32'd0);
        check("reset valid", b32(o_inst_valid), 32'd0);
        check("reset inst", o_inst, 32'd0);
        check("reset pc", o_pc, 32'd0);
        check("reset flush", b32(o_flush), 32'd0);
        check("reset misaligned", b32(o_misaligned), 32'd0);
        i_rst_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_flush;
    } vec_t;

    vec_t vecs[13];

    // Random-phase bookkeeping
    logic        p_redir, p_stall, p_ack, p_req, p_valid;
    logic [31:0] p_addr, p_pc, p_inst, exp_pc, tgt;
    logic        stall_n, redir_n, ack_n;
    int unsigned lat_left;
    int          consumed;

    initial begin
        // Zero-wait stream, 3-cycle stall at pc=8, then redirect with ack under stall.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8,   1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0, 32'h0,   1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h14,  1'b1, 32'h10,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 1'b0};

        do_reset(1'b0);
        for (int i = 0; i < 13; i++) begin
            seq($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                vecs[i].e_pc, vecs[i].e_flush, 1'b0,
                vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].ack);
        end

        // Redirect during a 3-cycle-latency fetch at 0x10: old address held, data dropped.
        do_reset(1'b0);
        seq("lat0", 1, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   1);
        seq("lat1", 1, 32'h4,   1, 32'h0,   0, 0, 0, 0, 32'h0,   1);
        seq("lat2", 1, 32'h8,   1, 32'h4,   0, 0, 0, 0, 32'h0,   1);
        seq("lat3", 1, 32'hC,   1, 32'h8,   0, 0, 0, 0, 32'h0,   1);
        seq("lat4", 1, 32'h10,  1, 32'hC,   0, 0, 0, 1, 32'h100, 0);
        seq("lat5", 1, 32'h10,  0, 32'h0,   1, 0, 0, 0, 32'h0,   0);
        seq("lat6", 1, 32'h10,  0, 32'h0,   0, 0, 0, 0, 32'h0,   1);
        seq("lat7", 1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1);
        seq("lat8", 1, 32'h104, 1, 32'h100, 0, 0, 0, 0, 32'h0,   0);

        // Misaligned target halts fetch; later redirects/acks ignored; reset with a stray ack.
        do_reset(1'b0);
        seq("mis0", 1, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0,   1);
        seq("mis1", 1, 32'h4, 1, 32'h0, 0, 0, 0, 1, 32'h102, 1);
        seq("mis2", 0, 32'h0, 0, 32'h0, 1, 1, 0, 1, 32'h200, 1);
        seq("mis3", 0, 32'h0, 0, 32'h0, 0, 1, 0, 1, 32'h300, 1);
        seq("mis4", 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0,   1);
        seq("mis5", 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0,   1);
        do_reset(1'b1);
        seq("rst0", 1, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0,   1);
        seq("rst1", 1, 32'h4, 1, 32'h0, 0, 0, 0, 0, 32'h0,   0);

        // PC wrap at the top of the address space.
        do_reset(1'b0);
        seq("wrap0", 1, 32'h0,         0, 32'h0,         0, 0, 0, 1, 32'hFFFF_FFF8, 1);
        seq("wrap1", 1, 32'hFFFF_FFF8, 0, 32'h0,         1, 0, 0, 0, 32'h0,         1);
        seq("wrap2", 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 32'h0,         1);
        seq("wrap3", 1, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0,         1);
        seq("wrap4", 1, 32'h4,         1, 32'h0,         0, 0, 0, 0, 32'h0,         0);

        // Randomized run: the consumed instruction stream must be program order
        // from the last redirect target, with handshake and hold rules upheld.
        do_reset(1'b0);
        exp_pc   = 32'h0;
        p_redir  = 1'b0; p_stall = 1'b0; p_ack = 1'b0; p_req = 1'b0; p_valid = 1'b0;
        p_addr   = '0;   p_pc    = '0;   p_inst = '0;
        lat_left = $urandom_range(0, 3);
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            check("rnd flush", b32(o_flush), b32(p_redir));
            check("rnd misaligned", b32(o_misaligned), 32'd0);
            if (p_redir) begin
                check("rnd squashed valid", b32(o_inst_valid), 32'd0);
            end else if (p_valid && p_stall) begin
                check("rnd hold valid", b32(o_inst_valid), 32'd1);
                check("rnd hold pc", o_pc, p_pc);
                check("rnd hold inst", o_inst, p_inst);
            end
            if (p_req && !p_ack) begin
                check("rnd req held", b32(imem.req), 32'd1);
                check("rnd addr held", imem.addr, p_addr);
            end

            stall_n = ($urandom_range(0, 2) == 0);
            redir_n = ($urandom_range(0, 15) == 0);
            tgt     = $urandom() & 32'hFFFF_FFFC;
            if (p_req && p_ack) lat_left = $urandom_range(0, 3);
            ack_n = 1'b0;
            if (imem.req) begin
                if (lat_left == 0) ack_n = 1'b1;
                else lat_left--;
            end

            if (o_inst_valid && !stall_n && !redir_n) begin
                check("rnd stream pc", o_pc, exp_pc);
                check("rnd stream inst", o_inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redir_n) exp_pc = tgt;

            drive(stall_n, redir_n, tgt, ack_n);
            p_redir = redir_n;  p_stall = stall_n; p_ack  = ack_n;
            p_req   = imem.req; p_valid = o_inst_valid;
            p_addr  = imem.addr; p_pc   = o_pc;    p_inst = o_inst;
        end
        check("rnd throughput", b32(consumed >= 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
